// File: rtl/whack_scorer_if.sv
// Bundle of the scorer's game-control, light/key inputs and score outputs.
// Macro WHACK_SCORER_STREAK_EN adds the streak and best_streak outputs.
interface whack_scorer_if #(
  parameter int unsigned NUM_LIGHTS = 9,
  parameter int unsigned CNT_W      = 6
);
  logic                  start;
  logic                  deathmatch;
  logic [CNT_W-1:0]      total_points;
  logic [NUM_LIGHTS-1:0] lights;
  logic                  key_valid;
  logic [3:0]            key_index;
  logic [CNT_W-1:0]      hits;
  logic [CNT_W-1:0]      misses;
  logic [CNT_W-1:0]      flicks;
  logic                  hit_pulse;
  logic                  miss_pulse;
  logic                  game_over;
  logic                  playing;
`ifdef WHACK_SCORER_STREAK_EN
  logic [CNT_W-1:0]      streak;
  logic [CNT_W-1:0]      best_streak;

  modport master (output start, deathmatch, total_points, lights, key_valid, key_index,
                  input  hits, misses, flicks, hit_pulse, miss_pulse, game_over, playing,
                         streak, best_streak);
  modport slave  (input  start, deathmatch, total_points, lights, key_valid, key_index,
                  output hits, misses, flicks, hit_pulse, miss_pulse, game_over, playing,
                         streak, best_streak);
`else
  modport master (output start, deathmatch, total_points, lights, key_valid, key_index,
                  input  hits, misses, flicks, hit_pulse, miss_pulse, game_over, playing);
  modport slave  (input  start, deathmatch, total_points, lights, key_valid, key_index,
                  output hits, misses, flicks, hit_pulse, miss_pulse, game_over, playing);
`endif
endinterface

// File: rtl/whack_scorer.sv
// Whack-a-mole scorer: judges each light flick as hit or miss and tracks the game.
// Macro WHACK_SCORER_STREAK_EN enables the streak / best_streak counters.
module whack_scorer #(
  parameter int unsigned NUM_LIGHTS = 9,
  parameter int unsigned CNT_W      = 6
) (
  input logic          clk,
  input logic          reset,
  whack_scorer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, LIT, OVER} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                state;
  logic [NUM_LIGHTS-1:0] lights_q;
  logic [3:0]            lit_idx;
  logic [CNT_W-1:0]      total_q;
  logic                  dm_q;

  logic [3:0]            new_idx;
  logic                  new_flick;
  logic                  judge;
  logic                  is_hit;
  logic [CNT_W-1:0]      flicks_n;
  logic                  game_end;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Descending scan so the lowest set bit wins on a non-one-hot vector.
  always_comb begin
    new_idx = '0;
    for (int unsigned i = NUM_LIGHTS; i > 0; i--) begin
      if (bus.lights[i-1]) new_idx = 4'(i - 1);
    end
    new_flick = (bus.lights != '0) && (bus.lights != lights_q);
    judge     = (state == LIT) && (bus.key_valid || (bus.lights != lights_q));
    // A press always decides the flick, even when the light changes on the same cycle.
    is_hit    = bus.key_valid && (bus.key_index == lit_idx);
    flicks_n  = sat_inc(bus.flicks);
    game_end  = (flicks_n == total_q) || (dm_q && !is_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      lights_q       <= '0;
      lit_idx        <= '0;
      total_q        <= '0;
      dm_q           <= 1'b0;
      bus.hits       <= '0;
      bus.misses     <= '0;
      bus.flicks     <= '0;
      bus.hit_pulse  <= 1'b0;
      bus.miss_pulse <= 1'b0;
      bus.game_over  <= 1'b0;
      bus.playing    <= 1'b0;
    end else begin
      lights_q       <= bus.lights;
      bus.hit_pulse  <= 1'b0;
      bus.miss_pulse <= 1'b0;
      if (bus.start) begin
        state         <= WAIT;
        total_q       <= bus.total_points;
        dm_q          <= bus.deathmatch;
        bus.hits      <= '0;
        bus.misses    <= '0;
        bus.flicks    <= '0;
        bus.game_over <= 1'b0;
        bus.playing   <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          WAIT: begin
            if (total_q == '0) begin
              state         <= OVER;
              bus.game_over <= 1'b1;
              bus.playing   <= 1'b0;
            end else if (new_flick) begin
              state   <= LIT;
              lit_idx <= new_idx;
            end
          end
          LIT: begin
            if (judge) begin
              bus.flicks <= flicks_n;
              if (is_hit) begin
                bus.hits      <= sat_inc(bus.hits);
                bus.hit_pulse <= 1'b1;
              end else begin
                bus.misses     <= sat_inc(bus.misses);
                bus.miss_pulse <= 1'b1;
              end
              if (game_end) begin
                state         <= OVER;
                bus.game_over <= 1'b1;
                bus.playing   <= 1'b0;
              end else if (new_flick) begin
                state   <= LIT;
                lit_idx <= new_idx;
              end else begin
                state <= WAIT;
              end
            end
          end
          OVER: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef WHACK_SCORER_STREAK_EN
  logic [CNT_W-1:0] streak_n;

  always_comb streak_n = is_hit ? sat_inc(bus.streak) : '0;

  always_ff @(posedge clk) begin
    if (reset || bus.start) begin
      bus.streak      <= '0;
      bus.best_streak <= '0;
    end else if (judge) begin
      bus.streak      <= streak_n;
      bus.best_streak <= (streak_n > bus.best_streak) ? streak_n : bus.best_streak;
    end
  end
`endif
endmodule

// File: tb/tb_whack_scorer.sv
// Directed bench for whack_scorer; build with WHACK_SCORER_STREAK_EN to cover streaks.
module tb_whack_scorer;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  whack_scorer_if #(.NUM_LIGHTS(9), .CNT_W(6)) bus ();
  whack_scorer #(.NUM_LIGHTS(9), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [5:0] tp, input logic dm);
    bus.start = 1'b1; bus.total_points = tp; bus.deathmatch = dm;
    step();
    bus.start = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1; bus.key_index = k;
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic set_lights(input logic [8:0] v);
    bus.lights = v;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    tests++;
    if ({bus.hits, bus.misses, bus.flicks, bus.hit_pulse, bus.miss_pulse, bus.game_over, bus.playing} !== 22'd0) begin
      fails++; $display("FAIL reset_state: got %h expected 0",
        {bus.hits, bus.misses, bus.flicks, bus.hit_pulse, bus.miss_pulse, bus.game_over, bus.playing});
    end
  endtask

  task automatic test_hit();
    start_game(6'd3, 1'b0);
    tests++;
    if ({bus.playing, bus.game_over, bus.flicks} !== {1'b1, 1'b0, 6'd0}) begin
      fails++; $display("FAIL start_playing: got %h expected %h", {bus.playing, bus.game_over, bus.flicks}, {1'b1, 1'b0, 6'd0});
    end
    set_lights(9'b000000100);
    press(4'd2);
    tests++;
    if ({bus.hit_pulse, bus.miss_pulse, bus.hits, bus.misses, bus.flicks} !== {1'b1, 1'b0, 6'd1, 6'd0, 6'd1}) begin
      fails++; $display("FAIL hit_judged: got %h expected %h",
        {bus.hit_pulse, bus.miss_pulse, bus.hits, bus.misses, bus.flicks}, {1'b1, 1'b0, 6'd1, 6'd0, 6'd1});
    end
    press(4'd2);
    step();
    tests++;
    if ({bus.hit_pulse, bus.hits, bus.flicks} !== {1'b0, 6'd1, 6'd1}) begin
      fails++; $display("FAIL extra_press_ignored: got %h expected %h", {bus.hit_pulse, bus.hits, bus.flicks}, {1'b0, 6'd1, 6'd1});
    end
  endtask

  task automatic test_miss_and_over();
    set_lights(9'b000010000);
    set_lights(9'b000000000);
    tests++;
    if ({bus.miss_pulse, bus.hit_pulse, bus.misses, bus.flicks} !== {1'b1, 1'b0, 6'd1, 6'd2}) begin
      fails++; $display("FAIL expiry_miss: got %h expected %h",
        {bus.miss_pulse, bus.hit_pulse, bus.misses, bus.flicks}, {1'b1, 1'b0, 6'd1, 6'd2});
    end
    step();
    tests++;
    if (bus.miss_pulse !== 1'b0) begin
      fails++; $display("FAIL miss_pulse_width: got %b expected 0", bus.miss_pulse);
    end
    set_lights(9'b001000000);
    press(4'd6);
    step();
    tests++;
    if ({bus.game_over, bus.playing, bus.hits, bus.misses, bus.flicks} !== {1'b1, 1'b0, 6'd2, 6'd1, 6'd3}) begin
      fails++; $display("FAIL budget_over: got %h expected %h",
        {bus.game_over, bus.playing, bus.hits, bus.misses, bus.flicks}, {1'b1, 1'b0, 6'd2, 6'd1, 6'd3});
    end
    set_lights(9'b000000010);
    press(4'd1);
    step();
    tests++;
    if ({bus.game_over, bus.hits, bus.misses, bus.flicks} !== {1'b1, 6'd2, 6'd1, 6'd3}) begin
      fails++; $display("FAIL over_holds: got %h expected %h",
        {bus.game_over, bus.hits, bus.misses, bus.flicks}, {1'b1, 6'd2, 6'd1, 6'd3});
    end
  endtask

  task automatic test_deathmatch();
    start_game(6'd25, 1'b1);
    tests++;
    if (bus.game_over !== 1'b0) begin
      fails++; $display("FAIL restart_clears_over: got %b expected 0", bus.game_over);
    end
    set_lights(9'b000000001);
    press(4'd7);
    tests++;
    if ({bus.miss_pulse, bus.misses, bus.flicks} !== {1'b1, 6'd1, 6'd1}) begin
      fails++; $display("FAIL dm_wrong_key: got %h expected %h", {bus.miss_pulse, bus.misses, bus.flicks}, {1'b1, 6'd1, 6'd1});
    end
    press(4'd0);
    tests++;
    if ({bus.game_over, bus.miss_pulse, bus.hit_pulse, bus.hits, bus.misses, bus.flicks} !== {1'b1, 1'b0, 1'b0, 6'd0, 6'd1, 6'd1}) begin
      fails++; $display("FAIL dm_over: got %h expected %h",
        {bus.game_over, bus.miss_pulse, bus.hit_pulse, bus.hits, bus.misses, bus.flicks}, {1'b1, 1'b0, 1'b0, 6'd0, 6'd1, 6'd1});
    end
  endtask

  task automatic test_press_on_expiry();
    start_game(6'd25, 1'b0);
    set_lights(9'b000100000);
    bus.lights = 9'b0;
    press(4'd5);
    tests++;
    if ({bus.hit_pulse, bus.miss_pulse, bus.hits, bus.misses, bus.flicks} !== {1'b1, 1'b0, 6'd1, 6'd0, 6'd1}) begin
      fails++; $display("FAIL press_wins: got %h expected %h",
        {bus.hit_pulse, bus.miss_pulse, bus.hits, bus.misses, bus.flicks}, {1'b1, 1'b0, 6'd1, 6'd0, 6'd1});
    end
  endtask

  task automatic test_direct_change();
    start_game(6'd25, 1'b0);
    set_lights(9'b000000010);
    set_lights(9'b000001000);
    tests++;
    if ({bus.miss_pulse, bus.misses, bus.flicks} !== {1'b1, 6'd1, 6'd1}) begin
      fails++; $display("FAIL direct_change_miss: got %h expected %h", {bus.miss_pulse, bus.misses, bus.flicks}, {1'b1, 6'd1, 6'd1});
    end
    press(4'd3);
    tests++;
    if ({bus.hit_pulse, bus.hits, bus.misses, bus.flicks} !== {1'b1, 6'd1, 6'd1, 6'd2}) begin
      fails++; $display("FAIL chained_flick_hit: got %h expected %h",
        {bus.hit_pulse, bus.hits, bus.misses, bus.flicks}, {1'b1, 6'd1, 6'd1, 6'd2});
    end
  endtask

  task automatic test_restart_discards();
    set_lights(9'b000010000);
    start_game(6'd25, 1'b0);
    set_lights(9'b000000000);
    step();
    tests++;
    if ({bus.miss_pulse, bus.hits, bus.misses, bus.flicks} !== 19'd0) begin
      fails++; $display("FAIL restart_discards: got %h expected 0", {bus.miss_pulse, bus.hits, bus.misses, bus.flicks});
    end
  endtask

  task automatic test_reset_mid_flick();
    set_lights(9'b000000100);
    press(4'd2);
    set_lights(9'b000010000);
    reset = 1'b1; step(); reset = 1'b0;
    tests++;
    if ({bus.hits, bus.misses, bus.flicks, bus.hit_pulse, bus.miss_pulse, bus.game_over, bus.playing} !== 22'd0) begin
      fails++; $display("FAIL reset_mid_flick: got %h expected 0",
        {bus.hits, bus.misses, bus.flicks, bus.hit_pulse, bus.miss_pulse, bus.game_over, bus.playing});
    end
    set_lights(9'b010000000);
    press(4'd7);
    step();
    tests++;
    if ({bus.hits, bus.misses, bus.flicks, bus.playing} !== 19'd0) begin
      fails++; $display("FAIL idle_ignores: got %h expected 0", {bus.hits, bus.misses, bus.flicks, bus.playing});
    end
  endtask

  task automatic test_zero_budget();
    start_game(6'd0, 1'b0);
    step();
    tests++;
    if ({bus.game_over, bus.playing, bus.flicks} !== {1'b1, 1'b0, 6'd0}) begin
      fails++; $display("FAIL zero_budget: got %h expected %h", {bus.game_over, bus.playing, bus.flicks}, {1'b1, 1'b0, 6'd0});
    end
  endtask

  task automatic test_boundaries();
    start_game(6'd25, 1'b0);
    set_lights(9'b100000000);
    press(4'd9);
    tests++;
    if ({bus.miss_pulse, bus.hit_pulse, bus.misses} !== {1'b1, 1'b0, 6'd1}) begin
      fails++; $display("FAIL key_out_of_range: got %h expected %h", {bus.miss_pulse, bus.hit_pulse, bus.misses}, {1'b1, 1'b0, 6'd1});
    end
    set_lights(9'b000101000);
    press(4'd3);
    tests++;
    if ({bus.hit_pulse, bus.hits, bus.misses, bus.flicks} !== {1'b1, 6'd1, 6'd1, 6'd2}) begin
      fails++; $display("FAIL lowest_bit_index: got %h expected %h",
        {bus.hit_pulse, bus.hits, bus.misses, bus.flicks}, {1'b1, 6'd1, 6'd1, 6'd2});
    end
  endtask

  task automatic test_streak();
    start_game(6'd25, 1'b0);
    set_lights(9'b000000000);
    set_lights(9'b000000001); press(4'd0);
    set_lights(9'b000000010); press(4'd1);
    set_lights(9'b000000100); press(4'd0);
    set_lights(9'b000001000); press(4'd3);
    tests++;
    if ({bus.hits, bus.misses, bus.flicks} !== {6'd3, 6'd1, 6'd4}) begin
      fails++; $display("FAIL streak_counts: got %h expected %h", {bus.hits, bus.misses, bus.flicks}, {6'd3, 6'd1, 6'd4});
    end
`ifdef WHACK_SCORER_STREAK_EN
    tests++;
    if ({bus.streak, bus.best_streak} !== {6'd1, 6'd2}) begin
      fails++; $display("FAIL streak_best: got %h expected %h", {bus.streak, bus.best_streak}, {6'd1, 6'd2});
    end
    start_game(6'd25, 1'b0);
    tests++;
    if ({bus.streak, bus.best_streak} !== 12'd0) begin
      fails++; $display("FAIL streak_start_clear: got %h expected 0", {bus.streak, bus.best_streak});
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.deathmatch = 1'b0; bus.total_points = '0;
    bus.lights = '0; bus.key_valid = 1'b0; bus.key_index = '0;
    test_reset();
    test_hit();
    test_miss_and_over();
    test_deathmatch();
    test_press_on_expiry();
    test_direct_change();
    test_restart_discards();
    test_reset_mid_flick();
    test_zero_budget();
    test_boundaries();
    test_streak();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/whack_scorer.md
Name: whack_scorer

Overview:
- Scoring stage directly downstream of the light controller and keypad controller in the whack-a-mole game.
- Consumes the one-hot light vector and decoded key presses, and judges each light flick as a hit or a miss.
- Accumulates hit, miss and flick counters and raises game_over when the flick budget is spent, or on the first miss in deathmatch mode.
- Its outputs feed the top-level LED/score display logic.

Parameters:
- NUM_LIGHTS, 9, number of light/key positions (key index range 0..NUM_LIGHTS-1).
- CNT_W, 6, width of every counter and of total_points (covers the 50-flick extended game).

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a game.
- deathmatch  input  1  1 = game ends on first miss; sampled on start.
- total_points  input  CNT_W  number of flicks in the game; sampled on start.
- lights  input  NUM_LIGHTS  one-hot active light from the light controller; all-zero = dark.
- key_valid  input  1  one-cycle pulse from the keypad controller; a debounced press occurred.
- key_index  input  4  pressed key, 0..NUM_LIGHTS-1; valid only with key_valid.
- hits  output  CNT_W  flicks judged hit.
- misses  output  CNT_W  flicks judged miss.
- flicks  output  CNT_W  flicks completed (hits+misses).
- hit_pulse  output  1  one-cycle pulse when a flick is judged hit.
- miss_pulse  output  1  one-cycle pulse when a flick is judged miss.
- game_over  output  1  high while in OVER.
- playing  output  1  high in WAIT or LIT.

Behaviour:
- Reset (sync, highest priority): state IDLE; hits, misses and flicks = 0; all pulses 0; game_over = 0; playing = 0; latched total_points and deathmatch = 0.
- States:
  - IDLE: waits for start.
  - WAIT: light dark, or current flick already judged.
  - LIT: flick active and not yet judged.
  - OVER: game finished.
- IDLE -> WAIT on start:
  - Clear all counters.
  - Latch total_points and deathmatch.
  - If latched total_points = 0, go straight to OVER the next cycle.
- start in WAIT, LIT or OVER restarts: same actions as from IDLE, and any open flick is discarded without judgement.
- Flick start: in WAIT, a lights value that is nonzero and differs from the previous cycle's lights (registered copy) opens a flick, records the lit index, and moves to LIT. A direct change from one index to another counts as a new flick.
- In LIT, evaluated on the same cycle's inputs:
  - key_valid with key_index equal to the lit index -> hit.
  - key_valid with any other index -> miss.
  - lights changes (to zero or another index) with no key_valid -> miss.
- If key_valid and a lights change coincide, the press is judged against the recorded index (press wins over expiry).
- Judgement:
  - On the cycle after the deciding input, the matching pulse is high for exactly one cycle and the counter plus flicks increment.
  - Next state is WAIT.
  - If lights changed to a new nonzero index on the deciding cycle, that new index opens the next flick immediately (WAIT is skipped, LIT persists with the new index).
- In WAIT, presses are ignored, including extra presses after a hit or presses during darkness.
- End of game: after the increment, if flicks = latched total_points, or (deathmatch and a miss was just judged), next state is OVER. OVER holds all counters and ignores lights and keys until start or reset.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Non-one-hot lights (more than one bit set) is a protocol violation. The lowest set bit is used as the index.
- key_index >= NUM_LIGHTS with key_valid in LIT counts as a miss.

Optional Feature:
- Macro WHACK_SCORER_STREAK_EN.
- Defined: adds outputs streak (CNT_W) and best_streak (CNT_W).
  - streak increments on each hit, clears to 0 on each miss.
  - best_streak = max(best_streak, streak) updated in the same cycle as the counters.
  - Both clear on reset and on start, and saturate like the other counters.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset then start with total_points=3, deathmatch=0; lights=9'b000000100, key 2 pressed -> hit_pulse one cycle, hits=1, flicks=1, state WAIT.
- Light on index 4 then lights=0 with no press -> miss_pulse, misses=1. After the 3rd flick -> game_over=1, flicks=3, and further presses do not change counters.
- deathmatch=1, total_points=25; wrong key 7 while index 0 lit -> misses=1, game_over=1 the cycle after the pulse; a second press during the same flick is ignored.
- Press on the exact cycle lights goes 0->... and lit index 5 -> 9'b0 with key 5 pressed in that cycle -> counted as hit, not miss.
- Lights change directly index 1 -> index 3 with no press -> one miss, new flick opened on index 3; key 3 then -> hit; flicks=2.
- Assert reset mid-flick -> all outputs 0 and state IDLE the next cycle. start with total_points=0 -> game_over=1 with flicks=0. STREAK_EN build: hit, hit, miss, hit -> streak=1, best_streak=2.
